bp_cache_req_responder: RTL and testbench

- Memory-side responder for one L1 cache's miss/uncached request interface. It accepts a cache request plus its metadata, writes back a dirty victim, fetches the fill block, and drives tag/data mem packets into the cache.
- It pulses cache_req_complete_o when the request is done.
- One instance sits between an FE (I$) or BE (D$) cache port and a simple block-granular memory command/response channel.

---
 rtl/bp_cache_req_responder.sv | 202 ++++++++++++++++++++
 tb/tb_bp_cache_req_responder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cache_req_responder.sv
// Memory-side responder for one L1 cache miss/uncached port: writes back a
// dirty victim, fetches the fill block and drives data/tag packets.
module bp_cache_req_responder #(
  parameter int paddr_width_p = 40,
  parameter int ptag_width_p  = 28,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512,
  parameter int dword_width_p = 64,
  localparam int lg_sets_lp   = $clog2(sets_p),
  localparam int lg_assoc_lp  = $clog2(assoc_p),
  localparam int offset_lp    = $clog2(block_width_p/8)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cache_req_v_i,
  output logic                     cache_req_ready_o,
  input  logic [1:0]               cache_req_type_i,
  input  logic [paddr_width_p-1:0] cache_req_addr_i,
  input  logic [dword_width_p-1:0] cache_req_data_i,
  input  logic                     cache_req_metadata_v_i,
  input  logic [lg_assoc_lp-1:0]   cache_req_repl_way_i,
  input  logic                     cache_req_dirty_i,
  output logic                     cache_req_complete_o,
  output logic                     data_mem_pkt_v_o,
  input  logic                     data_mem_pkt_ready_i,
  output logic [1:0]               data_mem_pkt_opcode_o,
  output logic [lg_sets_lp-1:0]    data_mem_pkt_index_o,
  output logic [lg_assoc_lp-1:0]   data_mem_pkt_way_o,
  output logic [block_width_p-1:0] data_mem_pkt_data_o,
  input  logic [block_width_p-1:0] data_mem_i,
  output logic                     tag_mem_pkt_v_o,
  input  logic                     tag_mem_pkt_ready_i,
  output logic [lg_sets_lp-1:0]    tag_mem_pkt_index_o,
  output logic [lg_assoc_lp-1:0]   tag_mem_pkt_way_o,
  output logic [ptag_width_p-1:0]  tag_mem_pkt_tag_o,
  output logic                     mem_cmd_v_o,
  input  logic                     mem_cmd_ready_i,
  output logic [1:0]               mem_cmd_type_o,
  output logic [paddr_width_p-1:0] mem_cmd_addr_o,
  output logic [block_width_p-1:0] mem_cmd_data_o,
  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_yumi_o,
  input  logic [block_width_p-1:0] mem_resp_data_i
);

  localparam logic [1:0] REQ_UC_LOAD  = 2'd2;
  localparam logic [1:0] REQ_UC_STORE = 2'd3;
  localparam int PAD_LP = block_width_p - dword_width_p;

  typedef enum logic [3:0] {
    S_READY, S_WAIT_META, S_WB_READ, S_WB_CAPT,
    S_WB_CMD, S_FILL_CMD, S_FILL_RESP, S_WR_DATA,
    S_WR_TAG, S_DONE, S_UC_CMD, S_UC_RESP, S_UC_DATA
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               type_q;
  logic [paddr_width_p-1:0] addr_q;
  logic [dword_width_p-1:0] data_q;
  logic [lg_assoc_lp-1:0]   way_q;
  logic                     dirty_q;
  logic                     meta_q;
  logic [block_width_p-1:0] blk_q;

  logic                     accept;
  logic                     meta_ok;
  logic                     dirty_eff;
  logic [lg_sets_lp-1:0]    idx;
  logic [paddr_width_p-1:0] blk_addr;

  assign accept    = (state_q == S_READY) & cache_req_v_i;
  assign meta_ok   = meta_q | cache_req_metadata_v_i;
  assign dirty_eff = meta_q ? dirty_q : cache_req_dirty_i;
  assign idx       = addr_q[offset_lp +: lg_sets_lp];
  assign blk_addr  = {addr_q[paddr_width_p-1:offset_lp],
                      {offset_lp{1'b0}}};

  always_comb begin
    state_d               = state_q;
    cache_req_ready_o     = (state_q == S_READY);
    cache_req_complete_o  = 1'b0;
    data_mem_pkt_v_o      = 1'b0;
    data_mem_pkt_opcode_o = 2'd0;
    data_mem_pkt_index_o  = idx;
    data_mem_pkt_way_o    = way_q;
    data_mem_pkt_data_o   = blk_q;
    tag_mem_pkt_v_o       = 1'b0;
    tag_mem_pkt_index_o   = idx;
    tag_mem_pkt_way_o     = way_q;
    tag_mem_pkt_tag_o     = addr_q[paddr_width_p-1 -: ptag_width_p];
    mem_cmd_v_o           = 1'b0;
    mem_cmd_type_o        = 2'd0;
    mem_cmd_addr_o        = blk_addr;
    mem_cmd_data_o        = blk_q;
    mem_resp_yumi_o       = 1'b0;
    case (state_q)
      S_READY: begin
        if (cache_req_v_i)
          state_d = cache_req_type_i[1] ? S_UC_CMD : S_WAIT_META;
      end
      S_WAIT_META: begin
        if (meta_ok)
          state_d = dirty_eff ? S_WB_READ : S_FILL_CMD;
      end
      S_WB_READ: begin
        data_mem_pkt_v_o      = 1'b1;
        data_mem_pkt_opcode_o = 2'd1;
        if (data_mem_pkt_ready_i) state_d = S_WB_CAPT;
      end
      S_WB_CAPT: state_d = S_WB_CMD;
      S_WB_CMD: begin
        // Victim tag is not tracked; writeback uses the request tag.
        mem_cmd_v_o    = 1'b1;
        mem_cmd_type_o = 2'd1;
        if (mem_cmd_ready_i) state_d = S_FILL_CMD;
      end
      S_FILL_CMD: begin
        mem_cmd_v_o    = 1'b1;
        mem_cmd_type_o = 2'd0;
        if (mem_cmd_ready_i) state_d = S_FILL_RESP;
      end
      S_FILL_RESP: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        data_mem_pkt_v_o      = 1'b1;
        data_mem_pkt_opcode_o = 2'd0;
        if (data_mem_pkt_ready_i) state_d = S_WR_TAG;
      end
      S_WR_TAG: begin
        tag_mem_pkt_v_o = 1'b1;
        if (tag_mem_pkt_ready_i) state_d = S_DONE;
      end
      S_DONE: begin
        cache_req_complete_o = 1'b1;
        state_d              = S_READY;
      end
      S_UC_CMD: begin
        mem_cmd_v_o    = 1'b1;
        mem_cmd_type_o = type_q;
        mem_cmd_addr_o = addr_q;
        mem_cmd_data_o = {{PAD_LP{1'b0}}, data_q};
        if (mem_cmd_ready_i) state_d = S_UC_RESP;
      end
      S_UC_RESP: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i)
          state_d = (type_q == REQ_UC_LOAD) ? S_UC_DATA : S_DONE;
      end
      S_UC_DATA: begin
        data_mem_pkt_v_o      = 1'b1;
        data_mem_pkt_opcode_o = 2'd2;
        data_mem_pkt_data_o   = {{PAD_LP{1'b0}},
                                 blk_q[dword_width_p-1:0]};
        if (data_mem_pkt_ready_i) state_d = S_DONE;
      end
      default: state_d = S_READY;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_READY;
      type_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      way_q   <= '0;
      dirty_q <= 1'b0;
      meta_q  <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q  <= cache_req_type_i;
        addr_q  <= cache_req_addr_i;
        data_q  <= (cache_req_type_i == REQ_UC_STORE)
                   ? cache_req_data_i : '0;
        meta_q  <= cache_req_metadata_v_i & ~cache_req_type_i[1];
        way_q   <= '0;
        dirty_q <= 1'b0;
        if (cache_req_metadata_v_i & ~cache_req_type_i[1]) begin
          way_q   <= cache_req_repl_way_i;
          dirty_q <= cache_req_dirty_i;
        end
      end
      if (state_q == S_WAIT_META && !meta_q
          && cache_req_metadata_v_i) begin
        meta_q  <= 1'b1;
        way_q   <= cache_req_repl_way_i;
        dirty_q <= cache_req_dirty_i;
      end
      if (state_q == S_WB_CAPT)
        blk_q <= data_mem_i;
      if ((state_q == S_FILL_RESP || state_q == S_UC_RESP)
          && mem_resp_v_i)
        blk_q <= mem_resp_data_i;
    end
  end

endmodule

// File: tb/tb_bp_cache_req_responder.sv
// Bench for bp_cache_req_responder: directed and random requests checked
// against a transfer-list model of the request/response protocol.
module tb_bp_cache_req_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         cache_req_v_i, cache_req_ready_o;
  logic [1:0]   cache_req_type_i;
  logic [39:0]  cache_req_addr_i;
  logic [63:0]  cache_req_data_i;
  logic         cache_req_metadata_v_i;
  logic [2:0]   cache_req_repl_way_i;
  logic         cache_req_dirty_i;
  logic         cache_req_complete_o;
  logic         data_mem_pkt_v_o, data_mem_pkt_ready_i;
  logic [1:0]   data_mem_pkt_opcode_o;
  logic [5:0]   data_mem_pkt_index_o;
  logic [2:0]   data_mem_pkt_way_o;
  logic [511:0] data_mem_pkt_data_o, data_mem_i;
  logic         tag_mem_pkt_v_o, tag_mem_pkt_ready_i;
  logic [5:0]   tag_mem_pkt_index_o;
  logic [2:0]   tag_mem_pkt_way_o;
  logic [27:0]  tag_mem_pkt_tag_o;
  logic         mem_cmd_v_o, mem_cmd_ready_i;
  logic [1:0]   mem_cmd_type_o;
  logic [39:0]  mem_cmd_addr_o;
  logic [511:0] mem_cmd_data_o;
  logic         mem_resp_v_i, mem_resp_yumi_o;
  logic [511:0] mem_resp_data_i;

  logic         stray_v, resp_active;
  logic [511:0] rsp_blk, wb_blk;
  assign mem_resp_v_i    = resp_active | stray_v;
  assign mem_resp_data_i = rsp_blk;
  assign data_mem_i      = wb_blk;

  bp_cache_req_responder dut (
    .clk_i(clk), .reset_i(reset),
    .cache_req_v_i(cache_req_v_i),
    .cache_req_ready_o(cache_req_ready_o),
    .cache_req_type_i(cache_req_type_i),
    .cache_req_addr_i(cache_req_addr_i),
    .cache_req_data_i(cache_req_data_i),
    .cache_req_metadata_v_i(cache_req_metadata_v_i),
    .cache_req_repl_way_i(cache_req_repl_way_i),
    .cache_req_dirty_i(cache_req_dirty_i),
    .cache_req_complete_o(cache_req_complete_o),
    .data_mem_pkt_v_o(data_mem_pkt_v_o),
    .data_mem_pkt_ready_i(data_mem_pkt_ready_i),
    .data_mem_pkt_opcode_o(data_mem_pkt_opcode_o),
    .data_mem_pkt_index_o(data_mem_pkt_index_o),
    .data_mem_pkt_way_o(data_mem_pkt_way_o),
    .data_mem_pkt_data_o(data_mem_pkt_data_o),
    .data_mem_i(data_mem_i),
    .tag_mem_pkt_v_o(tag_mem_pkt_v_o),
    .tag_mem_pkt_ready_i(tag_mem_pkt_ready_i),
    .tag_mem_pkt_index_o(tag_mem_pkt_index_o),
    .tag_mem_pkt_way_o(tag_mem_pkt_way_o),
    .tag_mem_pkt_tag_o(tag_mem_pkt_tag_o),
    .mem_cmd_v_o(mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_cmd_type_o(mem_cmd_type_o),
    .mem_cmd_addr_o(mem_cmd_addr_o),
    .mem_cmd_data_o(mem_cmd_data_o),
    .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .mem_resp_data_i(mem_resp_data_i)
  );

  typedef struct {
    logic [1:0] t; logic [39:0] a; logic [511:0] d;
  } cmd_t;
  typedef struct {
    logic [1:0] op; logic [5:0] idx; logic [2:0] way; logic [511:0] d;
  } dp_t;
  typedef struct {
    logic [5:0] idx; logic [2:0] way; logic [27:0] tag;
  } tp_t;

  cmd_t cmd_q[$];
  dp_t  dp_q[$];
  tp_t  tp_q[$];
  int   comp_cyc[$];
  int   acc_cyc = 0;
  int   cyc = 0;
  int   mode = 0;
  int   resp_delay = 0;
  int   checks = 0;
  int   errors = 0;
  int   stall_seen = 0;
  int   viol = 0;
  int   yumi_bad = 0;
  logic cmd_fire = 1'b0, dp_fire = 1'b0, tp_fire = 1'b0;
  logic resp_fire = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transfer monitor: logs handshakes and payload stability under stall.
  initial begin
    logic         pc_v, pc_r, pd_v, pd_r, pt_v, pt_r;
    logic [553:0] pc_p;
    logic [522:0] pd_p;
    logic [36:0]  pt_p;
    cmd_t c; dp_t p; tp_t g;
    pc_v = 0; pc_r = 0; pd_v = 0; pd_r = 0; pt_v = 0; pt_r = 0;
    pc_p = '0; pd_p = '0; pt_p = '0;
    forever begin
      @(negedge clk);
      cmd_fire  = mem_cmd_v_o & mem_cmd_ready_i;
      dp_fire   = data_mem_pkt_v_o & data_mem_pkt_ready_i;
      tp_fire   = tag_mem_pkt_v_o & tag_mem_pkt_ready_i;
      resp_fire = mem_resp_v_i & mem_resp_yumi_o;
      if (mem_resp_yumi_o && !mem_resp_v_i) yumi_bad++;
      if (cmd_fire) begin
        c.t = mem_cmd_type_o; c.a = mem_cmd_addr_o;
        c.d = mem_cmd_data_o; cmd_q.push_back(c);
      end
      if (dp_fire) begin
        p.op = data_mem_pkt_opcode_o; p.idx = data_mem_pkt_index_o;
        p.way = data_mem_pkt_way_o; p.d = data_mem_pkt_data_o;
        dp_q.push_back(p);
      end
      if (tp_fire) begin
        g.idx = tag_mem_pkt_index_o; g.way = tag_mem_pkt_way_o;
        g.tag = tag_mem_pkt_tag_o; tp_q.push_back(g);
      end
      if (cache_req_v_i && cache_req_ready_o) acc_cyc = cyc;
      if (cache_req_complete_o) comp_cyc.push_back(cyc);
      if (!reset) begin
        if (pc_v && !pc_r) begin
          stall_seen++;
          if (!mem_cmd_v_o || pc_p != {mem_cmd_type_o,
              mem_cmd_addr_o, mem_cmd_data_o}) viol++;
        end
        if (pd_v && !pd_r) begin
          stall_seen++;
          if (!data_mem_pkt_v_o || pd_p != {data_mem_pkt_opcode_o,
              data_mem_pkt_index_o, data_mem_pkt_way_o,
              data_mem_pkt_data_o}) viol++;
        end
        if (pt_v && !pt_r) begin
          stall_seen++;
          if (!tag_mem_pkt_v_o || pt_p != {tag_mem_pkt_index_o,
              tag_mem_pkt_way_o, tag_mem_pkt_tag_o}) viol++;
        end
      end
      pc_v = mem_cmd_v_o & ~reset; pc_r = mem_cmd_ready_i;
      pc_p = {mem_cmd_type_o, mem_cmd_addr_o, mem_cmd_data_o};
      pd_v = data_mem_pkt_v_o & ~reset; pd_r = data_mem_pkt_ready_i;
      pd_p = {data_mem_pkt_opcode_o, data_mem_pkt_index_o,
              data_mem_pkt_way_o, data_mem_pkt_data_o};
      pt_v = tag_mem_pkt_v_o & ~reset; pt_r = tag_mem_pkt_ready_i;
      pt_p = {tag_mem_pkt_index_o, tag_mem_pkt_way_o,
              tag_mem_pkt_tag_o};
    end
  end

  // Memory/cache environment: readies and delayed responses.
  initial begin
    int wcnt, cc, dc, tc;
    bit pend;
    resp_active = 0; pend = 0; wcnt = 0; cc = 0; dc = 0; tc = 0;
    mem_cmd_ready_i = 1; data_mem_pkt_ready_i = 1;
    tag_mem_pkt_ready_i = 1;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        resp_active = 0; pend = 0; cc = 0; dc = 0; tc = 0;
        mem_cmd_ready_i = 1; data_mem_pkt_ready_i = 1;
        tag_mem_pkt_ready_i = 1;
      end else begin
        if (resp_fire) resp_active = 0;
        if (cmd_fire) begin pend = 1; wcnt = resp_delay; end
        if (pend && !resp_active) begin
          if (wcnt == 0) begin resp_active = 1; pend = 0; end
          else wcnt--;
        end
        if (cmd_fire) cc = 0;
        if (dp_fire) dc = 0;
        if (tp_fire) tc = 0;
        case (mode)
          0: begin
            mem_cmd_ready_i = 1; data_mem_pkt_ready_i = 1;
            tag_mem_pkt_ready_i = 1;
          end
          1: begin
            mem_cmd_ready_i      = ($urandom_range(0, 2) != 0);
            data_mem_pkt_ready_i = ($urandom_range(0, 2) != 0);
            tag_mem_pkt_ready_i  = ($urandom_range(0, 2) != 0);
          end
          default: begin
            mem_cmd_ready_i = !(mem_cmd_v_o && cc < 5);
            if (mem_cmd_v_o && cc < 5) cc++;
            data_mem_pkt_ready_i = !(data_mem_pkt_v_o && dc < 5);
            if (data_mem_pkt_v_o && dc < 5) dc++;
            tag_mem_pkt_ready_i = !(tag_mem_pkt_v_o && tc < 5);
            if (tag_mem_pkt_v_o && tc < 5) tc++;
          end
        endcase
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 512'(cache_req_ready_o), 512'(1));
    chk({tag, "_valids"}, 512'({mem_cmd_v_o, data_mem_pkt_v_o,
        tag_mem_pkt_v_o, cache_req_complete_o, mem_resp_yumi_o}),
        512'(0));
  endtask

  task automatic run_txn(input logic [1:0] t, input logic [39:0] a,
      input logic [63:0] d, input logic [2:0] w, input logic dty,
      input int mk, input int md, input int rd,
      input logic [511:0] wb, input logic [511:0] rsp);
    cmd_t ec[$]; dp_t ed[$]; tp_t et[$];
    cmd_t c; dp_t p; tp_t g;
    int cb, db, tb, kb, sb, vb, yb, lat;
    logic [39:0] al;
    logic [5:0]  ix;
    logic [27:0] tg;
    mode = md; resp_delay = rd; wb_blk = wb; rsp_blk = rsp;
    cb = cmd_q.size(); db = dp_q.size(); tb = tp_q.size();
    kb = comp_cyc.size(); sb = stall_seen; vb = viol; yb = yumi_bad;
    al = a - (a % 40'd64);
    ix = 6'((a / 40'd64) % 40'd64);
    tg = 28'(a / 40'd4096);
    @(posedge clk); #1;
    cache_req_v_i = 1; cache_req_type_i = t; cache_req_addr_i = a;
    cache_req_data_i = d; cache_req_repl_way_i = w;
    cache_req_dirty_i = dty;
    cache_req_metadata_v_i = (t < 2'd2) && (mk == 0);
    @(negedge clk);
    chk("req_ready", 512'(cache_req_ready_o), 512'(1));
    for (int j = 1; j <= mk; j++) begin
      @(posedge clk); #1;
      cache_req_v_i = 0; cache_req_metadata_v_i = (j == mk);
    end
    @(posedge clk); #1;
    cache_req_v_i = 0; cache_req_metadata_v_i = 0;
    for (int k = 0; k < 600 && comp_cyc.size() == kb; k++)
      @(negedge clk);
    chk("complete_seen", 512'(comp_cyc.size() > kb), 512'(1));
    repeat (4) @(negedge clk);
    chk("complete_once", 512'(comp_cyc.size() - kb), 512'(1));
    if (t < 2'd2) begin
      if (dty) begin
        p.op = 1; p.idx = ix; p.way = w; p.d = '0; ed.push_back(p);
        c.t = 1; c.a = al; c.d = wb; ec.push_back(c);
      end
      c.t = 0; c.a = al; c.d = '0; ec.push_back(c);
      p.op = 0; p.idx = ix; p.way = w; p.d = rsp; ed.push_back(p);
      g.idx = ix; g.way = w; g.tag = tg; et.push_back(g);
      lat = 6 + ((mk > 1) ? mk - 1 : 0) + (dty ? 3 : 0);
    end else if (t == 2'd2) begin
      c.t = 2; c.a = a; c.d = '0; ec.push_back(c);
      p.op = 2; p.idx = ix; p.way = w; p.d = rsp; ed.push_back(p);
      lat = 4;
    end else begin
      c.t = 3; c.a = a; c.d = {448'd0, d}; ec.push_back(c);
      lat = 3;
    end
    if (md == 0 && rd == 0 && comp_cyc.size() > kb)
      chk("latency", 512'(comp_cyc[kb] - acc_cyc), 512'(lat));
    chk("cmd_count", 512'(cmd_q.size() - cb), 512'(ec.size()));
    for (int i = 0; i < ec.size() && cb + i < cmd_q.size(); i++) begin
      c = cmd_q[cb + i];
      chk("cmd_type", 512'(c.t), 512'(ec[i].t));
      chk("cmd_addr", 512'(c.a), 512'(ec[i].a));
      if (ec[i].t == 2'd1) chk("cmd_wb_data", c.d, ec[i].d);
      if (ec[i].t == 2'd3)
        chk("cmd_uc_data", 512'(c.d[63:0]), 512'(ec[i].d[63:0]));
    end
    chk("dpkt_count", 512'(dp_q.size() - db), 512'(ed.size()));
    for (int i = 0; i < ed.size() && db + i < dp_q.size(); i++) begin
      p = dp_q[db + i];
      chk("dpkt_op", 512'(p.op), 512'(ed[i].op));
      chk("dpkt_index", 512'(p.idx), 512'(ed[i].idx));
      if (ed[i].op != 2'd2)
        chk("dpkt_way", 512'(p.way), 512'(ed[i].way));
      if (ed[i].op == 2'd0) chk("dpkt_fill", p.d, ed[i].d);
      if (ed[i].op == 2'd2)
        chk("dpkt_uc", 512'(p.d[63:0]), 512'(ed[i].d[63:0]));
    end
    chk("tpkt_count", 512'(tp_q.size() - tb), 512'(et.size()));
    for (int i = 0; i < et.size() && tb + i < tp_q.size(); i++) begin
      g = tp_q[tb + i];
      chk("tpkt_index", 512'(g.idx), 512'(et[i].idx));
      chk("tpkt_way", 512'(g.way), 512'(et[i].way));
      chk("tpkt_tag", 512'(g.tag), 512'(et[i].tag));
    end
    chk("payload_stable", 512'(viol - vb), 512'(0));
    chk("yumi_without_v", 512'(yumi_bad - yb), 512'(0));
    if (md == 2)
      chk("stalls_seen", 512'(stall_seen > sb), 512'(1));
  endtask

  initial begin
    logic [63:0] r64;
    logic [1:0]  t;
    int cb, db, tb, kb, mk;
    reset = 1; stray_v = 0; rsp_blk = '0; wb_blk = '0;
    cache_req_v_i = 0; cache_req_type_i = 0; cache_req_addr_i = 0;
    cache_req_data_i = 0; cache_req_metadata_v_i = 0;
    cache_req_repl_way_i = 0; cache_req_dirty_i = 0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk_idle("post_reset");

    run_txn(2'd0, 40'h00_1234_5680, 64'd0, 3'd3, 1'b0, 0, 0, 0,
            rnd_blk(), {64{8'hA5}});
    run_txn(2'd1, 40'h00_0ABC_D7C0, 64'd0, 3'd5, 1'b1, 2, 0, 0,
            {32{16'hDEAD}}, rnd_blk());
    run_txn(2'd2, 40'h80_0000_0008, 64'd0, 3'd0, 1'b0, 0, 0, 0,
            rnd_blk(), {448'd0, 64'h1122334455667788});
    run_txn(2'd3, 40'h80_0000_0010, 64'hCAFE, 3'd0, 1'b0, 0, 0, 0,
            rnd_blk(), rnd_blk());
    run_txn(2'd0, 40'h12_3456_7840, 64'd0, 3'd6, 1'b1, 1, 2, 2,
            rnd_blk(), rnd_blk());

    @(posedge clk); #1;
    stray_v = 1;
    @(negedge clk);
    chk("stray_resp_yumi", 512'(mem_resp_yumi_o), 512'(0));
    @(negedge clk);
    chk("stray_resp_yumi2", 512'(mem_resp_yumi_o), 512'(0));
    @(posedge clk); #1;
    stray_v = 0;

    mode = 0; resp_delay = 100000;
    cb = cmd_q.size(); db = dp_q.size(); tb = tp_q.size();
    kb = comp_cyc.size();
    @(posedge clk); #1;
    cache_req_v_i = 1; cache_req_type_i = 0;
    cache_req_addr_i = 40'h00_5555_5540; cache_req_repl_way_i = 3'd2;
    cache_req_dirty_i = 0; cache_req_metadata_v_i = 1;
    @(posedge clk); #1;
    cache_req_v_i = 0; cache_req_metadata_v_i = 0;
    for (int k = 0; k < 50 && cmd_q.size() == cb; k++) @(negedge clk);
    chk("rst_fill_cmd_seen", 512'(cmd_q.size() - cb), 512'(1));
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk_idle("abort");
    @(negedge clk);
    chk_idle("abort_neg");
    @(posedge clk); #1;
    reset = 0; resp_delay = 0;
    repeat (10) @(negedge clk);
    chk("abort_no_cmd", 512'(cmd_q.size() - cb), 512'(1));
    chk("abort_no_dpkt", 512'(dp_q.size() - db), 512'(0));
    chk("abort_no_tpkt", 512'(tp_q.size() - tb), 512'(0));
    chk("abort_no_complete", 512'(comp_cyc.size() - kb), 512'(0));
    run_txn(2'd0, 40'h00_1234_5680, 64'd0, 3'd1, 1'b0, 0, 0, 0,
            rnd_blk(), rnd_blk());

    for (int n = 0; n < 24; n++) begin
      t = 2'($urandom_range(0, 3));
      r64 = {$urandom, $urandom};
      mk = (t < 2'd2) ? $urandom_range(0, 3) : 0;
      run_txn(t, r64[39:0], {$urandom, $urandom},
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              mk, $urandom_range(0, 2), $urandom_range(0, 3),
              rnd_blk(), rnd_blk());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
